scan_decoder: RTL
=================

Name: scan_decoder

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable and an autonomous scan mode. In direct mode it decodes the select input. In scan mode it sweeps the one-hot output across all 2^N lines, dwelling a programmable number of cycles on each line. It serves as the row/column select driver for multiplexed displays and banked enables, and replaces the fixed 64-output decoder tree with a single clocked block.

Parameters:
N, 6, select width; output width is 2^N (N >= 1).
DWELL, 4, cycles per output line in scan mode (DWELL >= 1).

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
w  input  N  select index (direct mode) or scan start index (on Load).
En  input  1  enable; 0 forces all outputs low and pauses scanning.
Mode  input  1  0 = direct, 1 = scan.
Load  input  1  in scan mode, loads w as the current index.
y  output  2^N  registered one-hot output.
idx  output  N  registered current index (the line driven when En=1).
wrap  output  1  one-cycle pulse when the scan index wraps from 2^N-1 to 0.

Behaviour:
- Reset (sampled high at a Clock edge): y=0, idx=0, dwell counter=0, wrap=0. Reset overrides every other input.
- Output rule: y is registered as y = En ? (1 << idx_next) : 0, so y always matches the idx it is presented with. Exactly one bit is set when En=1; no bits are set when En=0.
- Direct mode (Mode=0):
  - idx <= w every cycle; latency is 1 cycle from w/En to y.
  - The dwell counter is held at 0; wrap=0; Load is ignored.
- Scan mode (Mode=1, En=1):
  - The dwell counter counts 0..DWELL-1.
  - When the counter = DWELL-1: counter <= 0 and idx <= idx+1, mod 2^N.
  - The wrap pulse is asserted in the same cycle that idx becomes 0 by increment.
  - With DWELL=1, idx advances every cycle.
- Load (Mode=1): idx <= w and the counter <= 0, so the new line dwells a full DWELL cycles. Load has priority over the dwell advance; a Load of 0 does not pulse wrap.
- Scan with En=0: idx and counter hold, y=0, wrap=0. On En returning to 1, the same idx resumes with the remaining dwell count.
- Mode 0->1: scanning starts from the last direct idx with counter=0.
- Mode 1->0: idx <= w on that edge; any wrap that would have occurred is suppressed.
- Simultaneous inputs:
  - Reset beats everything.
  - In scan mode, Load beats the dwell advance.
  - En=0 blocks the advance but does not block Load; a loaded idx is stored while y stays 0.
- Width rules: idx increments wrap naturally at N bits. The counter width is clog2(DWELL), minimum 1 bit.
- Latency: y, idx and wrap are all registered, with no combinational input-to-output paths.

Decomposition:
- Shared package:
  - MODE_DIRECT=1'b0 and MODE_SCAN=1'b1 constants.
  - A clog2 function used to size the dwell counter.
- Sub-module dec_onehot (parametrised N, combinational): holds the N-to-2^N one-hot decode with enable, reusable elsewhere.
- The top holds only the idx/counter sequencing and the output registers.

Test Plan:
- Reset: hold Reset=1 with random w/En/Mode -> y=0, idx=0, wrap=0; release with Mode=0, En=1, w=6'd37 -> next cycle y has only bit 37 set, idx=37.
- Direct enable gating: Mode=0, w=6'd5, toggle En 1->0->1 -> y = bit 5, then 0, then bit 5, each 1 cycle after the En change; wrap stays 0.
- Scan dwell and wrap: N=6, DWELL=4, Load w=6'd62 in scan mode -> idx=62 for 4 cycles, then 63 for 4 cycles, then 0 with wrap=1 for exactly 1 cycle; y tracks idx.
- Pause/resume: scan at idx=10 with counter=2, drop En for 5 cycles -> y=0 and idx=10 held; after En=1, idx advances to 11 after exactly 2 more cycles.
- Load priority: Load with w=6'd3 on the same cycle the counter hits DWELL-1 -> idx=3 (not idx+1), followed by a full 4-cycle dwell.
- Reset mid-scan: assert Reset at idx=40, counter=1 -> next cycle y=0, idx=0, counter=0; with Mode=1 and En=1 held, scanning restarts from 0 with a full dwell and no wrap pulse.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared constants and helpers for the scan_decoder block.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Select/control inputs and decoded outputs of scan_decoder.
interface scan_decoder_if #(
    parameter int unsigned N = 6
) ();

    logic [N-1:0]      w;
    logic              En;
    logic              Mode;
    logic              Load;
    logic [(2**N)-1:0] y;
    logic [N-1:0]      idx;
    logic              wrap;

    modport master (
        output w, En, Mode, Load,
        input  y, idx, wrap
    );

    modport slave (
        input  w, En, Mode, Load,
        output y, idx, wrap
    );

endinterface

// File: rtl/scan_decoder_dec_onehot.sv
// Combinational N-to-2^N one-hot decoder with enable.
module dec_onehot #(
    parameter int unsigned N = 6
) (
    input  logic [N-1:0]      i_sel,
    input  logic              i_en,
    output logic [(2**N)-1:0] o_y_c
);

    always_comb begin
        o_y_c = '0;
        if (i_en) begin
            o_y_c[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct and autonomous dwell-scan modes.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned N     = 6,
    parameter int unsigned DWELL = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    scan_decoder_if.slave  bus
);

    localparam int unsigned LINES = 2 ** N;
    localparam int unsigned CW    = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [N-1:0]     r_idx;
    logic [CW-1:0]    r_cnt;
    logic [LINES-1:0] r_y;
    logic             r_wrap;

    logic [N-1:0]     w_idx_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_wrap_next;
    logic [LINES-1:0] w_y_next;

    // Index/dwell sequencing: Load beats the advance, En=0 only pauses the advance.
    always_comb begin
        w_idx_next  = r_idx;
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        if (bus.Mode == MODE_DIRECT) begin
            w_idx_next = bus.w;
            w_cnt_next = '0;
        end else if (bus.Load) begin
            w_idx_next = bus.w;
            w_cnt_next = '0;
        end else if (bus.En) begin
            if (r_cnt == CNT_LAST) begin
                w_cnt_next  = '0;
                w_idx_next  = r_idx + N'(1);
                w_wrap_next = (r_idx == {N{1'b1}});
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
    end

    // Decode the upcoming index so y always matches the idx it is registered with.
    dec_onehot #(
        .N (N)
    ) u_dec (
        .i_sel (w_idx_next),
        .i_en  (bus.En),
        .o_y_c (w_y_next)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_idx  <= w_idx_next;
            r_cnt  <= w_cnt_next;
            r_y    <= w_y_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bus.idx  = r_idx;
    assign bus.y    = r_y;
    assign bus.wrap = r_wrap;

endmodule
